shift_queue_multiport: RTL and testbench
========================================

Name: shift_queue_multiport

Overview:
- Collapsing, age-ordered shift queue. Multi-port successor to the single-port issue-queue shift queue.
- Accepts up to N_ENQ entries per cycle and removes up to N_DEQ arbitrarily selected entries per cycle. Survivors compact toward index 0, so index 0 is always the oldest entry.
- Supports in-place entry updates that follow the entry while it shifts, plus a synchronous flush.
- Sits between rename/dispatch and the issue selectors of the integer and LSU issue queues.

Parameters:
- N_ENTRIES, 8, queue depth; power of two not required.
- ENTRY_WIDTH, 32, bits per entry.
- N_ENQ, 2, enqueue lanes per cycle.
- N_DEQ, 2, maximum entries removed per cycle.
- CTR_WIDTH, $clog2(N_ENTRIES+1), derived localparam; width of count.

Ports:
- clk  in  1  clock.
- rst_aH  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous clear of all entries.
- enq_valid  in  N_ENQ  per-lane enqueue request.
- enq_data  in  N_ENQ x ENTRY_WIDTH  per-lane payload; lane 0 is older than lane 1.
- enq_ready  out  N_ENQ  per-lane acceptance.
- deq_sel_mask  in  N_ENTRIES  entries selected for removal.
- deq_ready  in  1  consumer accepts the selected entries this cycle.
- deq_valid  out  N_DEQ  output slot j holds a selected entry.
- deq_data  out  N_DEQ x ENTRY_WIDTH  slot j = j-th lowest selected entry.
- wr_en  in  N_ENTRIES  per-entry in-place write (e.g. operand wakeup).
- wr_data  in  N_ENTRIES x ENTRY_WIDTH  in-place write data, indexed by current position.
- entry_valid  out  N_ENTRIES  thermometer; bit i = (i < count).
- entry_douts  out  N_ENTRIES x ENTRY_WIDTH  current register contents.
- count  out  CTR_WIDTH  number of valid entries.

Behaviour:
- Reset (rst_aH high at posedge clk) has highest priority:
  - Next state: count=0, all entries=0.
  - Resulting outputs: entry_valid=0, entry_douts=0, deq_valid=0, deq_data=0, enq_ready all 1 (unless flush).
  - Reset mid-operation discards all in-flight enq/deq/wr that cycle.
- flush (second priority):
  - Next state: count=0, entries=0.
  - While flush is high: enq_ready=0 and deq_valid=0, regardless of other inputs.
- Dequeue selection:
  - eff_mask = deq_sel_mask & entry_valid; bits on invalid entries are ignored.
  - Only the N_DEQ lowest set bits of eff_mask are honoured (hon_mask). Extra bits are retained, not removed.
  - deq_valid[j] = popcount(hon_mask) > j.
  - deq_data[j] = entry at the j-th lowest set bit of hon_mask; 0 when deq_valid[j]=0.
  - n_deq = deq_ready ? popcount(hon_mask) : 0. Removal occurs only when deq_ready is high.
- Enqueue:
  - free = N_ENTRIES - count + n_deq. Same-cycle dequeue frees space (combinational path from deq_ready/deq_sel_mask to enq_ready; accepted).
  - rank[k] = popcount(enq_valid[k-1:0]).
  - enq_ready[k] = !flush && (free > rank[k]).
  - Lane k is accepted iff enq_valid[k] && enq_ready[k].
  - Accepted lanes are compacted: an invalid lane leaves no hole.
  - n_enq = number of accepted lanes.
- Next state, single cycle:
  1. Survivors = valid entries not in (deq_ready ? hon_mask : 0), kept in original age order, packed to indices 0..count-n_deq-1.
  2. A survivor whose old index i has wr_en[i] takes wr_data[i], otherwise keeps its value.
  3. Accepted lane of rank r is written to index count-n_deq+r.
  4. All indices >= count_next are cleared to 0.
  5. count_next = count - n_deq + n_enq. count never exceeds N_ENTRIES.
- wr_en targeting an invalid or dequeued entry is ignored.
- Latency:
  - Enqueued data is visible on entry_douts and selectable the next cycle.
  - Dequeue data is combinational from current state.
- Full with a simultaneous dequeue of k entries: exactly min(k, valid lanes) lanes are accepted.
- Empty: deq_valid=0 for any mask.
- Simulation-only checks (not synthesised):
  - popcount(eff_mask) > N_DEQ → error.
  - deq_sel_mask bits above count → warning.
  - count > N_ENTRIES → error.

Test Plan:
- Reset then fill, N_ENTRIES=8, N_ENQ=2, N_DEQ=2, W=8: enqueue pairs (0x10,0x11),(0x12,0x13),(0x14,0x15),(0x16,0x17) → count=8, entry_douts[0..7]=0x10..0x17, enq_ready=00.
- Full plus dequeue plus enqueue: count=8, deq_sel_mask=0b00100100, deq_ready=1, enq_valid=11 data (0xA0,0xA1):
  - Same cycle: deq_data=(0x12,0x15), enq_ready=11.
  - Next cycle: entries 0x10,0x11,0x13,0x14,0x16,0x17,0xA0,0xA1; count=8.
- Sparse enqueue: count=5, enq_valid=10 data lane1=0x55 → entry[5]=0x55, count=6, entry[6..7]=0.
- Write follows shift: entries 0x10..0x13, deq_sel_mask=0b0001, wr_en=0b0100, wr_data[2]=0xEE → next: 0x11,0xEE,0x13, count=3.
- Mask hygiene:
  - count=3, deq_sel_mask=0b11110000 → deq_valid=00, state unchanged.
  - deq_sel_mask=0b0111 with deq_ready=1 → only entries 0,1 removed, count=1.
  - deq_ready=0 with nonzero mask → deq_valid still asserted, no state change.
- Flush and reset priority: flush=1 with enq_valid=11 and deq_ready=1 → enq_ready=00, deq_valid=00, next count=0. Then rst_aH=1 with flush=0 and enqueue requests → count=0 and all entries 0 next cycle.

Source files
------------

// File: rtl/shift_queue_multiport.sv
// Collapsing, age-ordered multi-port shift queue.
// Index 0 always holds the oldest entry. Up to N_ENQ entries can be appended
// and up to N_DEQ arbitrarily selected entries removed in the same cycle.
// Survivors compact toward index 0. In-place writes follow an entry as it shifts.

// Simulation-only consistency checks for the queue; never synthesised into logic.
module shift_queue_multiport_chk #(
  parameter int N_ENTRIES       = 8,
  parameter int N_DEQ           = 2,
  parameter int CTR_WIDTH       = 4,
  parameter bit CHK_DEQ_OVERSEL = 1'b1
) (
  input logic                 clk,
  input logic                 rst_aH,
  input logic [N_ENTRIES-1:0] eff_mask,
  input logic [N_ENTRIES-1:0] sel_mask,
  input logic [CTR_WIDTH-1:0] count
);

  // Flag over-selection, selections past the valid region and count overflow.
  always_ff @(posedge clk) begin
    if (!rst_aH) begin
      if (CHK_DEQ_OVERSEL) begin
        assert ($countones(eff_mask) <= N_DEQ)
          else $error("shift_queue_multiport: more than N_DEQ valid entries selected");
      end
      assert (int'(count) <= N_ENTRIES)
        else $error("shift_queue_multiport: count exceeds N_ENTRIES");
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (sel_mask[i] && (i >= int'(count))) begin
          $warning("shift_queue_multiport: deq_sel_mask bit %0d at or above count", i);
        end
      end
    end
  end

endmodule

module shift_queue_multiport #(
  parameter int N_ENTRIES       = 8,
  parameter int ENTRY_WIDTH     = 32,
  parameter int N_ENQ           = 2,
  parameter int N_DEQ           = 2,
  // Enables the simulation check on selecting more than N_DEQ valid entries.
  parameter bit CHK_DEQ_OVERSEL = 1'b1,
  localparam int CTR_WIDTH      = $clog2(N_ENTRIES + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_aH,
  input  logic                                  flush,
  input  logic [N_ENQ-1:0]                      enq_valid,
  input  logic [N_ENQ-1:0][ENTRY_WIDTH-1:0]     enq_data,
  output logic [N_ENQ-1:0]                      enq_ready,
  input  logic [N_ENTRIES-1:0]                  deq_sel_mask,
  input  logic                                  deq_ready,
  output logic [N_DEQ-1:0]                      deq_valid,
  output logic [N_DEQ-1:0][ENTRY_WIDTH-1:0]     deq_data,
  input  logic [N_ENTRIES-1:0]                  wr_en,
  input  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] wr_data,
  output logic [N_ENTRIES-1:0]                  entry_valid,
  output logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] entry_douts,
  output logic [CTR_WIDTH-1:0]                  count
);

  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] r_entries;
  logic [CTR_WIDTH-1:0]                  r_count;

  logic [N_ENTRIES-1:0]                  w_entry_valid;
  logic [N_ENTRIES-1:0]                  w_eff_mask;
  logic [N_ENTRIES-1:0]                  w_hon_mask;
  logic [N_ENTRIES-1:0]                  w_remove_mask;
  logic [N_DEQ-1:0]                      w_deq_valid;
  logic [N_DEQ-1:0][ENTRY_WIDTH-1:0]     w_deq_data;
  int                                    w_n_hon;
  int                                    w_n_deq;
  int                                    w_free;
  logic [N_ENQ-1:0]                      w_enq_ready;
  logic [N_ENQ-1:0]                      w_enq_acc;
  int                                    w_enq_rank [N_ENQ];
  int                                    w_n_enq;
  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] w_entries_nxt;
  int                                    w_count_nxt;

  // Thermometer of occupied slots derived from the registered count.
  always_comb begin
    w_entry_valid = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (i < int'(r_count)) begin
        w_entry_valid[i] = 1'b1;
      end else begin
        w_entry_valid[i] = 1'b0;
      end
    end
  end

  assign w_eff_mask = deq_sel_mask & w_entry_valid;

  // Honour only the N_DEQ oldest selected entries and route them to output slots.
  always_comb begin
    int v_cnt;
    v_cnt       = 0;
    w_hon_mask  = '0;
    w_deq_valid = '0;
    w_deq_data  = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (w_eff_mask[i] && (v_cnt < N_DEQ)) begin
        for (int j = 0; j < N_DEQ; j++) begin
          if (j == v_cnt) begin
            w_deq_valid[j] = 1'b1;
            w_deq_data[j]  = r_entries[i];
          end else begin
            w_deq_valid[j] = w_deq_valid[j];
          end
        end
        w_hon_mask[i] = 1'b1;
        v_cnt         = v_cnt + 1;
      end else begin
        w_hon_mask[i] = 1'b0;
      end
    end
    w_n_hon = v_cnt;
  end

  // Removal only happens when the consumer takes the honoured entries.
  always_comb begin
    if (deq_ready) begin
      w_n_deq       = w_n_hon;
      w_remove_mask = w_hon_mask;
    end else begin
      w_n_deq       = 0;
      w_remove_mask = '0;
    end
  end

  // Enqueue acceptance: space freed by a same-cycle dequeue is usable immediately.
  always_comb begin
    int v_rank;
    v_rank      = 0;
    w_n_enq     = 0;
    w_free      = N_ENTRIES - int'(r_count) + w_n_deq;
    w_enq_ready = '0;
    w_enq_acc   = '0;
    for (int k = 0; k < N_ENQ; k++) begin
      w_enq_rank[k] = v_rank;
      if (!flush && (w_free > v_rank)) begin
        w_enq_ready[k] = 1'b1;
      end else begin
        w_enq_ready[k] = 1'b0;
      end
      w_enq_acc[k] = enq_valid[k] & w_enq_ready[k];
      if (enq_valid[k]) begin
        v_rank = v_rank + 1;
      end else begin
        v_rank = v_rank;
      end
      if (w_enq_acc[k]) begin
        w_n_enq = w_n_enq + 1;
      end else begin
        w_n_enq = w_n_enq;
      end
    end
  end

  // Next contents: compact survivors (with in-place writes), then append accepted lanes.
  always_comb begin
    int v_kept;
    v_kept        = 0;
    w_entries_nxt = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (w_entry_valid[i] && !w_remove_mask[i]) begin
        for (int d = 0; d < N_ENTRIES; d++) begin
          if (d == v_kept) begin
            if (wr_en[i]) begin
              w_entries_nxt[d] = wr_data[i];
            end else begin
              w_entries_nxt[d] = r_entries[i];
            end
          end else begin
            w_entries_nxt[d] = w_entries_nxt[d];
          end
        end
        v_kept = v_kept + 1;
      end else begin
        v_kept = v_kept;
      end
    end
    for (int k = 0; k < N_ENQ; k++) begin
      if (w_enq_acc[k]) begin
        for (int d = 0; d < N_ENTRIES; d++) begin
          if (d == (v_kept + w_enq_rank[k])) begin
            w_entries_nxt[d] = enq_data[k];
          end else begin
            w_entries_nxt[d] = w_entries_nxt[d];
          end
        end
      end else begin
        w_entries_nxt = w_entries_nxt;
      end
    end
    w_count_nxt = v_kept + w_n_enq;
  end

  // State register: reset beats flush, flush beats normal update.
  always_ff @(posedge clk) begin
    if (rst_aH) begin
      r_count   <= '0;
      r_entries <= '0;
    end else if (flush) begin
      r_count   <= '0;
      r_entries <= '0;
    end else begin
      r_count   <= CTR_WIDTH'(w_count_nxt);
      r_entries <= w_entries_nxt;
    end
  end

  // Dequeue outputs are suppressed while flushing.
  always_comb begin
    if (flush) begin
      deq_valid = '0;
      deq_data  = '0;
    end else begin
      deq_valid = w_deq_valid;
      deq_data  = w_deq_data;
    end
  end

  assign enq_ready   = w_enq_ready;
  assign entry_valid = w_entry_valid;
  assign entry_douts = r_entries;
  assign count       = r_count;

  shift_queue_multiport_chk #(
    .N_ENTRIES       (N_ENTRIES),
    .N_DEQ           (N_DEQ),
    .CTR_WIDTH       (CTR_WIDTH),
    .CHK_DEQ_OVERSEL (CHK_DEQ_OVERSEL)
  ) u_chk (
    .clk      (clk),
    .rst_aH   (rst_aH),
    .eff_mask (w_eff_mask),
    .sel_mask (deq_sel_mask),
    .count    (r_count)
  );

endmodule

// File: tb/tb_shift_queue_multiport.sv
// Self-checking bench for shift_queue_multiport (N_ENTRIES=8, W=8, N_ENQ=2, N_DEQ=2).
module tb_shift_queue_multiport;

  localparam int NE = 8;
  localparam int W  = 8;
  localparam int NQ = 2;
  localparam int ND = 2;

  logic                clk = 1'b0;
  logic                rst_aH;
  logic                flush;
  logic [NQ-1:0]       enq_valid;
  logic [NQ-1:0][W-1:0] enq_data;
  logic [NQ-1:0]       enq_ready;
  logic [NE-1:0]       deq_sel_mask;
  logic                deq_ready;
  logic [ND-1:0]       deq_valid;
  logic [ND-1:0][W-1:0] deq_data;
  logic [NE-1:0]       wr_en;
  logic [NE-1:0][W-1:0] wr_data;
  logic [NE-1:0]       entry_valid;
  logic [NE-1:0][W-1:0] entry_douts;
  logic [3:0]          count;

  always #5 clk = ~clk;

  shift_queue_multiport #(
    .N_ENTRIES       (NE),
    .ENTRY_WIDTH     (W),
    .N_ENQ           (NQ),
    .N_DEQ           (ND),
    .CHK_DEQ_OVERSEL (1'b0)
  ) dut (
    .clk          (clk),
    .rst_aH       (rst_aH),
    .flush        (flush),
    .enq_valid    (enq_valid),
    .enq_data     (enq_data),
    .enq_ready    (enq_ready),
    .deq_sel_mask (deq_sel_mask),
    .deq_ready    (deq_ready),
    .deq_valid    (deq_valid),
    .deq_data     (deq_data),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .entry_valid  (entry_valid),
    .entry_douts  (entry_douts),
    .count        (count)
  );

  typedef struct {
    logic       rst;
    logic       flush;
    logic [1:0] enq_valid;
    logic [7:0] enq0;
    logic [7:0] enq1;
    logic [7:0] sel;
    logic       deq_ready;
    logic [7:0] wr_en;
    logic [7:0] wr_val;
    logic       chk_comb;
    logic [1:0] exp_enq_ready;
    logic [1:0] exp_deq_valid;
    logic [7:0] exp_deq0;
    logic [7:0] exp_deq1;
    logic [3:0] exp_count;
  } vec_t;

  typedef struct {
    logic [3:0]  cnt;
    logic [63:0] douts;
    logic [7:0]  valid;
  } snap_t;

  vec_t        vecs[$];
  snap_t       sb[$];
  logic [7:0]  q_model[$];
  logic [1:0]  m_enq_ready;
  logic [1:0]  m_deq_valid;
  logic [15:0] m_deq_data;
  logic [7:0]  m_hon;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour of the same-cycle outputs, from the model queue and bench inputs.
  task automatic model_comb();
    int cnt;
    int ndeq;
    int free;
    int rank;
    cnt        = 0;
    m_hon      = 8'h00;
    m_deq_data = 16'h0000;
    for (int i = 0; i < q_model.size(); i++) begin
      if (deq_sel_mask[i] && cnt < ND) begin
        if (cnt == 0) m_deq_data[7:0] = q_model[i];
        else          m_deq_data[15:8] = q_model[i];
        m_hon[i] = 1'b1;
        cnt++;
      end
    end
    m_deq_valid = (cnt == 0) ? 2'b00 : ((cnt == 1) ? 2'b01 : 2'b11);
    if (flush) begin
      m_deq_valid = 2'b00;
      m_deq_data  = 16'h0000;
    end
    ndeq = deq_ready ? cnt : 0;
    free = NE - q_model.size() + ndeq;
    rank = 0;
    for (int k = 0; k < NQ; k++) begin
      m_enq_ready[k] = !flush && (free > rank);
      if (enq_valid[k]) rank++;
    end
  endtask

  // Advance the model queue by one clock and push the expected state to the scoreboard.
  task automatic model_step();
    logic [7:0] nq[$];
    snap_t      s;
    if (!rst_aH && !flush) begin
      for (int i = 0; i < q_model.size(); i++) begin
        if (!(deq_ready && m_hon[i])) nq.push_back(wr_en[i] ? wr_data[i] : q_model[i]);
      end
      for (int k = 0; k < NQ; k++) begin
        if (enq_valid[k] && m_enq_ready[k]) nq.push_back(enq_data[k]);
      end
    end
    q_model = nq;
    s.cnt   = 4'(q_model.size());
    s.douts = 64'h0;
    s.valid = 8'h00;
    for (int i = 0; i < q_model.size(); i++) begin
      s.douts[i*8 +: 8] = q_model[i];
      s.valid[i]        = 1'b1;
    end
    sb.push_back(s);
  endtask

  // Clock edge, then pop the expected state and compare the registered outputs.
  task automatic clock_and_compare(input string tag);
    snap_t s;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
    end else begin
      s = sb.pop_front();
      check({tag, " count"}, 64'(count), 64'(s.cnt));
      check({tag, " entry_douts"}, 64'(entry_douts), s.douts);
      check({tag, " entry_valid"}, 64'(entry_valid), 64'(s.valid));
    end
  endtask

  task automatic drive(input vec_t v);
    rst_aH       = v.rst;
    flush        = v.flush;
    enq_valid    = v.enq_valid;
    enq_data[0]  = v.enq0;
    enq_data[1]  = v.enq1;
    deq_sel_mask = v.sel;
    deq_ready    = v.deq_ready;
    wr_en        = v.wr_en;
    for (int i = 0; i < NE; i++) wr_data[i] = v.wr_val;
  endtask

  initial begin
    // rst, flush, enq_valid, enq0, enq1, sel, deq_ready, wr_en, wr_val,
    // chk_comb, exp_enq_ready, exp_deq_valid, exp_deq0, exp_deq1, exp_count
    vecs.push_back(vec_t'{1'b0,1'b0,2'b11,8'h10,8'h11,8'h00,1'b0,8'h00,8'h00, 1'b1,2'b11,2'b00,8'h00,8'h00,4'd2});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b11,8'h12,8'h13,8'h00,1'b0,8'h00,8'h00, 1'b1,2'b11,2'b00,8'h00,8'h00,4'd4});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b11,8'h14,8'h15,8'h00,1'b0,8'h00,8'h00, 1'b1,2'b11,2'b00,8'h00,8'h00,4'd6});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b11,8'h16,8'h17,8'h00,1'b0,8'h00,8'h00, 1'b1,2'b11,2'b00,8'h00,8'h00,4'd8});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b00,8'h00,8'h00,8'h00,1'b0,8'h00,8'h00, 1'b1,2'b00,2'b00,8'h00,8'h00,4'd8});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b11,8'hA0,8'hA1,8'h24,1'b1,8'h00,8'h00, 1'b1,2'b11,2'b11,8'h12,8'h15,4'd8});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b00,8'h00,8'h00,8'hC0,1'b1,8'h00,8'h00, 1'b1,2'b11,2'b11,8'hA0,8'hA1,4'd6});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b00,8'h00,8'h00,8'h01,1'b1,8'h00,8'h00, 1'b1,2'b11,2'b01,8'h10,8'h00,4'd5});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b10,8'h99,8'h55,8'h00,1'b0,8'h00,8'h00, 1'b1,2'b11,2'b00,8'h00,8'h00,4'd6});
    vecs.push_back(vec_t'{1'b0,1'b1,2'b11,8'h33,8'h34,8'h03,1'b1,8'h00,8'h00, 1'b1,2'b00,2'b00,8'h00,8'h00,4'd0});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b11,8'h10,8'h11,8'h00,1'b0,8'h00,8'h00, 1'b1,2'b11,2'b00,8'h00,8'h00,4'd2});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b11,8'h12,8'h13,8'h00,1'b0,8'h00,8'h00, 1'b1,2'b11,2'b00,8'h00,8'h00,4'd4});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b00,8'h00,8'h00,8'h01,1'b1,8'h04,8'hEE, 1'b1,2'b11,2'b01,8'h10,8'h00,4'd3});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b00,8'h00,8'h00,8'hF0,1'b1,8'h00,8'h00, 1'b1,2'b11,2'b00,8'h00,8'h00,4'd3});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b00,8'h00,8'h00,8'h06,1'b0,8'h00,8'h00, 1'b1,2'b11,2'b11,8'hEE,8'h13,4'd3});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b00,8'h00,8'h00,8'h07,1'b1,8'h00,8'h00, 1'b1,2'b11,2'b11,8'h11,8'hEE,4'd1});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b01,8'h66,8'h00,8'h00,1'b0,8'hFE,8'h5A, 1'b1,2'b11,2'b00,8'h00,8'h00,4'd2});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b11,8'h20,8'h21,8'h00,1'b0,8'h00,8'h00, 1'b1,2'b11,2'b00,8'h00,8'h00,4'd4});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b11,8'h22,8'h23,8'h00,1'b0,8'h00,8'h00, 1'b1,2'b11,2'b00,8'h00,8'h00,4'd6});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b11,8'h24,8'h25,8'h00,1'b0,8'h00,8'h00, 1'b1,2'b11,2'b00,8'h00,8'h00,4'd8});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b11,8'hB0,8'hB1,8'h02,1'b1,8'h00,8'h00, 1'b1,2'b01,2'b01,8'h66,8'h00,4'd8});
    vecs.push_back(vec_t'{1'b1,1'b0,2'b11,8'hC0,8'hC1,8'hFF,1'b1,8'hFF,8'h77, 1'b0,2'b00,2'b00,8'h00,8'h00,4'd0});
    vecs.push_back(vec_t'{1'b0,1'b0,2'b00,8'h00,8'h00,8'hFF,1'b1,8'h00,8'h00, 1'b1,2'b11,2'b00,8'h00,8'h00,4'd0});

    // Hand sequence: reset held for two cycles with enqueue requests pending.
    rst_aH       = 1'b1;
    flush        = 1'b0;
    enq_valid    = 2'b11;
    enq_data[0]  = 8'hE0;
    enq_data[1]  = 8'hE1;
    deq_sel_mask = 8'hFF;
    deq_ready    = 1'b1;
    wr_en        = 8'h00;
    wr_data      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset count", 64'(count), 64'd0);
    check("reset entry_valid", 64'(entry_valid), 64'h0);
    check("reset entry_douts", 64'(entry_douts), 64'h0);
    check("reset enq_ready", 64'(enq_ready), 64'h3);
    check("reset deq_valid", 64'(deq_valid), 64'h0);
    check("reset deq_data", 64'(deq_data), 64'h0);
    q_model.delete();

    // Table-driven vectors: same-cycle outputs at negedge, next state after the edge.
    for (int r = 0; r < vecs.size(); r++) begin
      drive(vecs[r]);
      @(negedge clk);
      if (vecs[r].chk_comb) begin
        check($sformatf("row%0d enq_ready", r), 64'(enq_ready), 64'(vecs[r].exp_enq_ready));
        check($sformatf("row%0d deq_valid", r), 64'(deq_valid), 64'(vecs[r].exp_deq_valid));
        check($sformatf("row%0d deq_data", r), 64'(deq_data),
              64'({vecs[r].exp_deq1, vecs[r].exp_deq0}));
      end
      model_comb();
      model_step();
      clock_and_compare($sformatf("row%0d", r));
      check($sformatf("row%0d table count", r), 64'(count), 64'(vecs[r].exp_count));
    end

    // Randomised sequence checked against the queue model through the scoreboard.
    for (int c = 0; c < 300; c++) begin
      logic [7:0] therm;
      therm = 8'h00;
      for (int i = 0; i < q_model.size(); i++) therm[i] = 1'b1;
      rst_aH       = 1'b0;
      flush        = ($urandom_range(0, 31) == 0);
      enq_valid    = 2'($urandom_range(0, 3));
      enq_data[0]  = 8'($urandom);
      enq_data[1]  = 8'($urandom);
      deq_sel_mask = 8'($urandom) & therm;
      deq_ready    = ($urandom_range(0, 3) != 0);
      wr_en        = 8'($urandom) & 8'($urandom);
      for (int i = 0; i < NE; i++) wr_data[i] = 8'($urandom);
      @(negedge clk);
      model_comb();
      check($sformatf("rand%0d enq_ready", c), 64'(enq_ready), 64'(m_enq_ready));
      check($sformatf("rand%0d deq_valid", c), 64'(deq_valid), 64'(m_deq_valid));
      check($sformatf("rand%0d deq_data", c), 64'(deq_data), 64'(m_deq_data));
      model_step();
      clock_and_compare($sformatf("rand%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
